// File: rtl/dbus_initiator_pkg.sv
// Shared definitions for the data-bus initiator: FSM encoding, bus width and
// the peripheral address map decoded on adr[31:24].
package dbus_initiator_pkg;

  localparam int DBUS_W = 32;

  localparam logic [7:0] TIMER_BASE = 8'hc0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } dbus_state_e;

  function automatic logic is_timer_adr(input logic [DBUS_W-1:0] adr);
    return adr[31:24] == TIMER_BASE;
  endfunction

endpackage

// File: rtl/dbus_initiator_if.sv
// Command/response handshake and SoC data-bus signals of the initiator.
// master is the initiator side; slave is the command source plus responders.
interface dbus_initiator_if import dbus_initiator_pkg::*; ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [DBUS_W-1:0] req_adr;
  logic [DBUS_W-1:0] req_dat;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DBUS_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_we;

  logic [DBUS_W-1:0] wb_dbus_adr;
  logic [DBUS_W-1:0] wb_dbus_dat;
  logic              wb_dbus_we;
  logic              wb_dbus_cyc;
  logic [DBUS_W-1:0] wb_dbus_rdt;
  logic              wb_dbus_ack;

  modport master (
    input  req_valid, req_we, req_adr, req_dat, rsp_ready, wb_dbus_rdt, wb_dbus_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we,
           wb_dbus_adr, wb_dbus_dat, wb_dbus_we, wb_dbus_cyc
  );

  modport slave (
    output req_valid, req_we, req_adr, req_dat, rsp_ready, wb_dbus_rdt, wb_dbus_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we,
           wb_dbus_adr, wb_dbus_dat, wb_dbus_we, wb_dbus_cyc
  );

endinterface

// File: rtl/dbus_initiator.sv
// Single-outstanding data-bus initiator: accepts one command, runs one cyc
// pulse with ack/timeout completion, then holds the response until taken.
module dbus_initiator import dbus_initiator_pkg::*; #(
  parameter int                TIMEOUT     = 255,
  parameter logic [DBUS_W-1:0] RD_ERR_DATA = 32'h0
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  dbus_initiator_if.master       bus,
  output logic                   busy
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  dbus_state_e       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req_ready;
  logic              r_cyc;
  logic              r_we;
  logic [DBUS_W-1:0] r_adr;
  logic [DBUS_W-1:0] r_dat;
  logic              r_rsp_valid;
  logic [DBUS_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_we;
  logic              r_busy;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (r_req_ready && bus.req_valid) begin
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_cyc       <= 1'b1;
            r_we        <= bus.req_we;
            r_adr       <= bus.req_adr;
            r_dat       <= bus.req_dat;
            r_cnt       <= '0;
            r_state     <= BUS;
          end
        end
        BUS: begin
          // ack takes priority, so an ack on the last allowed cycle still completes
          if (bus.wb_dbus_ack || r_cnt == CNT_LAST) begin
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_we    <= r_we;
            r_state     <= RESP;
            if (bus.wb_dbus_ack) begin
              r_rsp_rdata <= r_we ? '0 : bus.wb_dbus_rdt;
              r_rsp_err   <= 1'b0;
            end else begin
              r_rsp_rdata <= RD_ERR_DATA;
              r_rsp_err   <= 1'b1;
            end
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_we      = r_rsp_we;
  assign bus.wb_dbus_adr = r_adr;
  assign bus.wb_dbus_dat = r_dat;
  assign bus.wb_dbus_we  = r_we;
  assign bus.wb_dbus_cyc = r_cyc;
  assign busy            = r_busy;

endmodule

// File: tb/tb_dbus_initiator.sv
// Randomized bench for dbus_initiator with a behavioural timer responder and
// a transaction-level reference model of completion, timeout and data.
module tb_dbus_initiator;
  import dbus_initiator_pkg::*;

  localparam int          TO       = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic wb_clk = 1'b0;
  logic wb_rst;
  logic busy;

  dbus_initiator_if bus ();

  dbus_initiator #(
    .TIMEOUT     (TO),
    .RD_ERR_DATA (ERR_DATA)
  ) dut (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 wb_clk = ~wb_clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Responder knobs, set by the stimulus
  int          lat          = 1;
  int          force_ack_at = 0;
  logic [31:0] force_rdt    = 32'h0;
  logic        stray_ack    = 1'b0;

  logic [31:0] resp_mem  [16] = '{default: 32'h0};
  logic [31:0] model_mem [16] = '{default: 32'h0};

  // Timer responder: acks after lat cycles of cyc; everything else stays silent
  int rcnt = 0;
  always @(posedge wb_clk) begin
    #2;
    if (bus.wb_dbus_cyc) begin
      rcnt = rcnt + 1;
      if (is_timer_adr(bus.wb_dbus_adr) && rcnt == lat) begin
        bus.wb_dbus_ack = 1'b1;
        bus.wb_dbus_rdt = bus.wb_dbus_we ? 32'h0 : resp_mem[bus.wb_dbus_adr[5:2]];
        if (bus.wb_dbus_we) resp_mem[bus.wb_dbus_adr[5:2]] = bus.wb_dbus_dat;
      end else if (force_ack_at != 0 && rcnt == force_ack_at) begin
        bus.wb_dbus_ack = 1'b1;
        bus.wb_dbus_rdt = force_rdt;
      end else begin
        bus.wb_dbus_ack = 1'b0;
        bus.wb_dbus_rdt = 32'h0;
      end
    end else begin
      rcnt = 0;
      bus.wb_dbus_ack = stray_ack;
      bus.wb_dbus_rdt = stray_ack ? 32'hFFFF_FFFF : 32'h0;
    end
  end

  // Every-cycle bus discipline
  always @(negedge wb_clk) begin
    if (wb_rst === 1'b0) begin
      if (!bus.wb_dbus_cyc) begin
        check_val("idle_adr", bus.wb_dbus_adr, 32'h0);
        check_val("idle_dat", bus.wb_dbus_dat, 32'h0);
        check_val("idle_we", 32'(bus.wb_dbus_we), 32'h0);
      end
      check_val("vld_rdy_excl", 32'(bus.rsp_valid & bus.req_ready), 32'h0);
    end
  end

  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input int hold, input string tag);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_len;
    int          cyc_cnt;
    int          waited;
    logic [31:0] held;

    if (is_timer_adr(adr)) begin
      exp_len   = lat;
      exp_err   = 1'b0;
      exp_rdata = we ? 32'h0 : model_mem[adr[5:2]];
      if (we) model_mem[adr[5:2]] = dat;
    end else if (force_ack_at != 0 && force_ack_at <= TO) begin
      exp_len   = force_ack_at;
      exp_err   = 1'b0;
      exp_rdata = we ? 32'h0 : force_rdt;
    end else begin
      exp_len   = TO;
      exp_err   = 1'b1;
      exp_rdata = ERR_DATA;
    end

    bus.rsp_ready = (hold == 0);
    waited = 0;
    while (!bus.req_ready && waited < 50) begin
      @(negedge wb_clk);
      waited++;
    end
    check_val({tag, "_req_ready_wait"}, 32'(waited < 50), 32'h1);

    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_adr   = adr;
    bus.req_dat   = dat;
    @(negedge wb_clk);
    bus.req_valid = 1'b0;
    bus.req_adr   = $urandom;
    bus.req_dat   = $urandom;
    check_val({tag, "_first_cyc"}, 32'(bus.wb_dbus_cyc), 32'h1);

    cyc_cnt = 0;
    waited  = 0;
    while (!bus.rsp_valid && waited < 200) begin
      if (bus.wb_dbus_cyc) begin
        cyc_cnt++;
        check_val({tag, "_bus_adr"}, bus.wb_dbus_adr, adr);
        check_val({tag, "_bus_dat"}, bus.wb_dbus_dat, dat);
        check_val({tag, "_bus_we"}, 32'(bus.wb_dbus_we), 32'(we));
      end
      @(negedge wb_clk);
      waited++;
    end
    check_val({tag, "_rsp_wait"}, 32'(waited < 200), 32'h1);
    check_val({tag, "_cyc_len"}, 32'(cyc_cnt), 32'(exp_len));
    check_val({tag, "_latency"}, 32'(waited), 32'(exp_len));
    check_val({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
    check_val({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
    check_val({tag, "_rsp_we"}, 32'(bus.rsp_we), 32'(we));
    check_val({tag, "_busy"}, 32'(busy), 32'h1);
    $display("txn %s we=%0b adr=%h dat=%h rdata=%h err=%0b cyc_len=%0d", tag, we, adr, dat,
             bus.rsp_rdata, bus.rsp_err, cyc_cnt);

    held = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge wb_clk);
      check_val({tag, "_hold_rdata"}, bus.rsp_rdata, held);
      check_val({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'h1);
      check_val({tag, "_hold_req_ready"}, 32'(bus.req_ready), 32'h0);
      check_val({tag, "_hold_cyc"}, 32'(bus.wb_dbus_cyc), 32'h0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge wb_clk);
    check_val({tag, "_rsp_done"}, 32'(bus.rsp_valid), 32'h0);
    check_val({tag, "_back_idle"}, 32'(bus.req_ready), 32'h1);
    check_val({tag, "_not_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    logic        r_we_rand;
    logic [31:0] r_adr_rand;
    int          waited;

    wb_rst        = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_adr   = 32'h0;
    bus.req_dat   = 32'h0;
    bus.rsp_ready = 1'b1;
    #1;
    check_val("rst_cyc", 32'(bus.wb_dbus_cyc), 32'h0);
    check_val("rst_adr", bus.wb_dbus_adr, 32'h0);
    check_val("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    check_val("rst_release_ready", 32'(bus.req_ready), 32'h1);

    // Write then read back through the timer
    lat = 3;
    run_txn(1'b1, 32'hc000_0008, 32'h1234_1234, 0, "wr_timer");
    lat = 2;
    run_txn(1'b0, 32'hc000_0008, 32'h0, 0, "rd_timer");

    // Unmapped read times out
    run_txn(1'b0, 32'h5000_0000, 32'h0, 0, "unmapped");

    // Response backpressure
    lat = 4;
    run_txn(1'b0, 32'hc000_0000, 32'h0, 10, "backpressure");

    // Ack arriving on the final timeout cycle
    force_ack_at = TO;
    force_rdt    = 32'hA5A5_5A5A;
    run_txn(1'b0, 32'h5000_0004, 32'h0, 0, "coincident");
    force_ack_at = 0;

    // Stray ack while idle
    stray_ack = 1'b1;
    @(negedge wb_clk);
    @(negedge wb_clk);
    stray_ack = 1'b0;
    repeat (2) @(negedge wb_clk);
    check_val("stray_busy", 32'(busy), 32'h0);
    check_val("stray_req_ready", 32'(bus.req_ready), 32'h1);
    check_val("stray_rsp_valid", 32'(bus.rsp_valid), 32'h0);

    // Reset in the middle of a bus cycle
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_adr   = 32'h4400_0010;
    bus.req_dat   = 32'h0;
    @(negedge wb_clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge wb_clk);
    check_val("midbus_cyc_before", 32'(bus.wb_dbus_cyc), 32'h1);
    wb_rst = 1'b1;
    #1;
    check_val("midbus_cyc_async", 32'(bus.wb_dbus_cyc), 32'h0);
    check_val("midbus_adr_async", bus.wb_dbus_adr, 32'h0);
    check_val("midbus_busy_async", 32'(busy), 32'h0);
    check_val("midbus_req_ready", 32'(bus.req_ready), 32'h0);
    @(negedge wb_clk);
    wb_rst = 1'b0;
    waited = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk);
      if (bus.rsp_valid) waited++;
    end
    check_val("midbus_no_rsp", 32'(waited), 32'h0);
    lat = 1;
    run_txn(1'b0, 32'hc000_0008, 32'h0, 0, "after_reset");

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      r_we_rand = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        r_adr_rand = {4'h4, 4'($urandom_range(0, 15)), 24'($urandom_range(0, 255)) << 2};
      else
        r_adr_rand = {8'hc0, 24'($urandom_range(0, 15)) << 2};
      lat = $urandom_range(1, 6);
      run_txn(r_we_rand, r_adr_rand, $urandom, $urandom_range(0, 3) == 0 ? 2 : 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
